// File: rtl/mem_arbiter_2.sv
// Two-port (instruction/data) arbiter in front of the 32-to-16 bridge host port.
// Registers the granted request onto m_* and routes completion and read data back.
module mem_arbiter_2 #(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_cs,
    input  logic [29:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic        i_wr_en,
    input  logic [3:0]  i_bytesel,
    output logic [31:0] i_rdata,
    output logic        i_compl,
    input  logic        d_cs,
    input  logic [29:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic        d_wr_en,
    input  logic [3:0]  d_bytesel,
    output logic [31:0] d_rdata,
    output logic        d_compl,
    output logic        m_cs,
    output logic [29:0] m_addr,
    output logic [31:0] m_wdata,
    output logic        m_wr_en,
    output logic [3:0]  m_bytesel,
    input  logic [31:0] m_rdata,
    input  logic        m_compl
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        WAIT
    } state_t;

    state_t state;
    logic   last_d;
    logic   i_req;
    logic   d_req;
    logic   tie_i;
    logic   pick_i;
    logic   pick_d;

    // A zero byte mask is a no-op, so it never counts as a request.
    always_comb begin
        i_req  = i_cs && (|i_bytesel);
        d_req  = d_cs && (|d_bytesel);
        tie_i  = ROUND_ROBIN ? last_d : 1'b0;
        pick_i = i_req && (!d_req || tie_i);
        pick_d = d_req && !pick_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last_d    <= 1'b1;
            m_cs      <= 1'b0;
            m_addr    <= '0;
            m_wdata   <= '0;
            m_wr_en   <= 1'b0;
            m_bytesel <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            i_compl   <= 1'b0;
            d_compl   <= 1'b0;
        end else begin
            i_compl <= 1'b0;
            d_compl <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pick_i) begin
                        m_cs      <= 1'b1;
                        m_addr    <= i_addr;
                        m_wdata   <= i_wdata;
                        m_wr_en   <= i_wr_en;
                        m_bytesel <= i_bytesel;
                        last_d    <= 1'b0;
                        state     <= BUSY_I;
                    end else if (pick_d) begin
                        m_cs      <= 1'b1;
                        m_addr    <= d_addr;
                        m_wdata   <= d_wdata;
                        m_wr_en   <= d_wr_en;
                        m_bytesel <= d_bytesel;
                        last_d    <= 1'b1;
                        state     <= BUSY_D;
                    end
                end
                BUSY_I: begin
                    if (m_compl) begin
                        if (!m_wr_en) begin
                            i_rdata <= m_rdata;
                        end
                        i_compl   <= 1'b1;
                        m_cs      <= 1'b0;
                        m_wr_en   <= 1'b0;
                        m_bytesel <= '0;
                        state     <= WAIT;
                    end
                end
                BUSY_D: begin
                    if (m_compl) begin
                        if (!m_wr_en) begin
                            d_rdata <= m_rdata;
                        end
                        d_compl   <= 1'b1;
                        m_cs      <= 1'b0;
                        m_wr_en   <= 1'b0;
                        m_bytesel <= '0;
                        state     <= WAIT;
                    end
                end
                // Gives the requester a cycle to drop cs after its completion.
                WAIT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter_2.sv
// Bench for mem_arbiter_2: a round-robin and a fixed-priority instance
// share requester inputs; each has its own bridge completion line.
module tb_mem_arbiter_2;

    localparam int PI = 0;
    localparam int PD = 1;

    logic clk = 1'b0;
    logic rst_n;

    logic        rq_cs    [2];
    logic [29:0] rq_addr  [2];
    logic [31:0] rq_wdata [2];
    logic        rq_we    [2];
    logic [3:0]  rq_bs    [2];

    wire logic        i_cs      = rq_cs[PI];
    wire logic [29:0] i_addr    = rq_addr[PI];
    wire logic [31:0] i_wdata   = rq_wdata[PI];
    wire logic        i_wr_en   = rq_we[PI];
    wire logic [3:0]  i_bytesel = rq_bs[PI];
    wire logic        d_cs      = rq_cs[PD];
    wire logic [29:0] d_addr    = rq_addr[PD];
    wire logic [31:0] d_wdata   = rq_wdata[PD];
    wire logic        d_wr_en   = rq_we[PD];
    wire logic [3:0]  d_bytesel = rq_bs[PD];

    logic [31:0] m_rdata;
    logic [1:0]  m_compl;

    logic [1:0][31:0] i_rdata_o;
    logic [1:0][31:0] d_rdata_o;
    logic [1:0]       i_compl_o;
    logic [1:0]       d_compl_o;
    logic [1:0]       m_cs;
    logic [1:0][29:0] m_addr;
    logic [1:0][31:0] m_wdata;
    logic [1:0]       m_wr_en;
    logic [1:0][3:0]  m_bytesel;

    int n_assert = 0;
    int n_fail   = 0;

    // Expected held read data per instance and port.
    logic [31:0] exp_rd [2][2];

    mem_arbiter_2 #(.ROUND_ROBIN(1'b1)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .i_cs(i_cs), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_wr_en(i_wr_en), .i_bytesel(i_bytesel),
        .i_rdata(i_rdata_o[0]), .i_compl(i_compl_o[0]),
        .d_cs(d_cs), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wr_en(d_wr_en), .d_bytesel(d_bytesel),
        .d_rdata(d_rdata_o[0]), .d_compl(d_compl_o[0]),
        .m_cs(m_cs[0]), .m_addr(m_addr[0]), .m_wdata(m_wdata[0]),
        .m_wr_en(m_wr_en[0]), .m_bytesel(m_bytesel[0]),
        .m_rdata(m_rdata), .m_compl(m_compl[0])
    );

    mem_arbiter_2 #(.ROUND_ROBIN(1'b0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .i_cs(i_cs), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_wr_en(i_wr_en), .i_bytesel(i_bytesel),
        .i_rdata(i_rdata_o[1]), .i_compl(i_compl_o[1]),
        .d_cs(d_cs), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wr_en(d_wr_en), .d_bytesel(d_bytesel),
        .d_rdata(d_rdata_o[1]), .d_compl(d_compl_o[1]),
        .m_cs(m_cs[1]), .m_addr(m_addr[1]), .m_wdata(m_wdata[1]),
        .m_wr_en(m_wr_en[1]), .m_bytesel(m_bytesel[1]),
        .m_rdata(m_rdata), .m_compl(m_compl[1])
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic cmp(input int k, input int p);
        return (p == PI) ? i_compl_o[k] : d_compl_o[k];
    endfunction

    task automatic set_req(input int p, input logic cs, input logic [29:0] a,
                           input logic [31:0] w, input logic we,
                           input logic [3:0] bs);
        rq_cs[p]    = cs;
        rq_addr[p]  = a;
        rq_wdata[p] = w;
        rq_we[p]    = we;
        rq_bs[p]    = bs;
    endtask

    task automatic rand_req(input int p);
        logic [3:0] bs;
        bs = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        set_req(p, ($urandom_range(0, 3) != 0), 30'($urandom), $urandom,
                1'($urandom), bs);
    endtask

    task automatic clear_exp(input int k);
        exp_rd[k][PI] = '0;
        exp_rd[k][PD] = '0;
    endtask

    task automatic chk_reset(input int k, input string tag);
        check({tag, "_m_cs"}, 32'(m_cs[k]), 32'd0);
        check({tag, "_m_addr"}, 32'(m_addr[k]), 32'd0);
        check({tag, "_m_wdata"}, m_wdata[k], 32'd0);
        check({tag, "_m_wr_en"}, 32'(m_wr_en[k]), 32'd0);
        check({tag, "_m_bytesel"}, 32'(m_bytesel[k]), 32'd0);
        check({tag, "_i_rdata"}, i_rdata_o[k], 32'd0);
        check({tag, "_d_rdata"}, d_rdata_o[k], 32'd0);
        check({tag, "_compl"}, 32'({i_compl_o[k], d_compl_o[k]}), 32'd0);
    endtask

    // Bridge model plus checks for one transfer of port p on instance k.
    // Entered just after a negedge; returns at the negedge after Ec+1.
    task automatic transfer(input int k, input int p, input int lat,
                            input logic [31:0] rd, input bit drop);
        int          n;
        int          q;
        logic [29:0] ea;
        logic [31:0] ew;
        logic        ewe;
        logic [3:0]  ebs;
        n   = 0;
        q   = 1 - p;
        ea  = rq_addr[p];
        ew  = rq_wdata[p];
        ewe = rq_we[p];
        ebs = rq_bs[p];
        do begin
            @(negedge clk);
            n++;
        end while (!m_cs[k] && n < 20);
        check("grant_latency", 32'(n), 32'd1);
        if (!m_cs[k]) return;
        check("m_addr", 32'(m_addr[k]), 32'(ea));
        check("m_wdata", m_wdata[k], ew);
        check("m_wr_en", 32'(m_wr_en[k]), 32'(ewe));
        check("m_bytesel", 32'(m_bytesel[k]), 32'(ebs));
        if (drop) rq_cs[p] = 1'b0;
        for (int c = 1; c < lat; c++) begin
            @(negedge clk);
            check("m_cs_hold", 32'(m_cs[k]), 32'd1);
            check("m_addr_hold", 32'(m_addr[k]), 32'(ea));
            check("early_compl", 32'({cmp(k, PI), cmp(k, PD)}), 32'd0);
        end
        m_rdata    = rd;
        m_compl[k] = 1'b1;
        @(negedge clk);
        m_compl[k] = 1'b0;
        m_rdata    = $urandom;
        if (!ewe) exp_rd[k][p] = rd;
        check("compl", 32'(cmp(k, p)), 32'd1);
        check("other_compl", 32'(cmp(k, q)), 32'd0);
        check("i_rdata", i_rdata_o[k], exp_rd[k][PI]);
        check("d_rdata", d_rdata_o[k], exp_rd[k][PD]);
        check("m_cs_drop", 32'(m_cs[k]), 32'd0);
        check("m_bytesel_clr", 32'(m_bytesel[k]), 32'd0);
        check("m_wr_en_clr", 32'(m_wr_en[k]), 32'd0);
        @(negedge clk);
        check("compl_pulse", 32'({cmp(k, PI), cmp(k, PD)}), 32'd0);
        check("m_cs_gap", 32'(m_cs[k]), 32'd0);
    endtask

    initial begin
        int  n;
        bit  vi;
        bit  vd;
        int  w;
        bit  last_d;

        rst_n   = 1'b0;
        m_rdata = '0;
        m_compl = '0;
        set_req(PI, 1'b0, '0, '0, 1'b0, 4'h0);
        set_req(PD, 1'b0, '0, '0, 1'b0, 4'h0);
        clear_exp(0);
        clear_exp(1);
        repeat (3) @(negedge clk);
        chk_reset(0, "reset_rr");
        chk_reset(1, "reset_fp");
        rst_n = 1'b1;
        @(negedge clk);

        // Single instruction read.
        set_req(PI, 1'b1, 30'h0000100, 32'h0, 1'b0, 4'hF);
        transfer(0, PI, 3, 32'hDEADBEEF, 1'b0);
        rq_cs[PI] = 1'b0;

        // Single data write at the top address.
        set_req(PD, 1'b1, 30'h3FFFFFFF, 32'h12345678, 1'b1, 4'b1100);
        transfer(0, PD, 2, 32'hA5A5A5A5, 1'b0);
        rq_cs[PD] = 1'b0;

        // Both held: round robin alternates starting with i.
        set_req(PI, 1'b1, 30'h0000200, 32'h1111, 1'b0, 4'h3);
        set_req(PD, 1'b1, 30'h0000300, 32'h2222, 1'b0, 4'hF);
        transfer(0, PI, 1, 32'hCAFE0001, 1'b0);
        transfer(0, PD, 2, 32'hCAFE0002, 1'b0);
        transfer(0, PI, 3, 32'hCAFE0003, 1'b0);
        transfer(0, PD, 1, 32'hCAFE0004, 1'b0);
        rq_cs[PI] = 1'b0;

        // Back-to-back data requests from a held cs.
        transfer(0, PD, 2, 32'hB0B0B0B0, 1'b0);
        transfer(0, PD, 4, 32'hB1B1B1B1, 1'b0);
        rq_cs[PD] = 1'b0;

        // cs without byte enables is never granted.
        set_req(PI, 1'b1, 30'h123, 32'h5, 1'b0, 4'h0);
        set_req(PD, 1'b1, 30'h456, 32'h6, 1'b1, 4'h0);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check("zero_bytesel_no_grant", 32'(m_cs[0]), 32'd0);
        end

        // Requester drops cs mid-transfer; completion still arrives.
        set_req(PD, 1'b0, '0, '0, 1'b0, 4'h0);
        set_req(PI, 1'b1, 30'h0ABCDEF, 32'h0, 1'b0, 4'h5);
        transfer(0, PI, 3, 32'h600DF00D, 1'b1);
        @(negedge clk);
        check("no_regrant_after_drop", 32'(m_cs[0]), 32'd0);

        // Randomized traffic against the round-robin rule.
        last_d = 1'b0;
        rand_req(PI);
        rand_req(PD);
        for (int it = 0; it < 24; it++) begin
            vi = rq_cs[PI] && (|rq_bs[PI]);
            vd = rq_cs[PD] && (|rq_bs[PD]);
            if (!vi && !vd) begin
                repeat (3) begin
                    @(negedge clk);
                    check("rand_no_grant", 32'(m_cs[0]), 32'd0);
                end
                rand_req(PI);
                rand_req(PD);
                continue;
            end
            if (vi && vd) w = last_d ? PI : PD;
            else          w = vi ? PI : PD;
            transfer(0, w, $urandom_range(1, 4), $urandom, 1'b0);
            last_d = (w == PD);
            rand_req(w);
            if (!(w == PI ? vd : vi)) rand_req(1 - w);
        end
        set_req(PI, 1'b0, '0, '0, 1'b0, 4'h0);
        set_req(PD, 1'b0, '0, '0, 1'b0, 4'h0);
        repeat (3) @(negedge clk);

        // Reset during BUSY_I, then a stray bridge completion.
        set_req(PI, 1'b1, 30'h0000777, 32'h0, 1'b0, 4'hF);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!m_cs[0] && n < 20);
        check("pre_reset_grant", 32'(m_cs[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        clear_exp(0);
        clear_exp(1);
        chk_reset(0, "mid_reset");
        rq_cs[PI] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        m_rdata = 32'hBADBAD00;
        m_compl = 2'b11;
        @(negedge clk);
        m_compl = 2'b00;
        chk_reset(0, "stray_compl");
        @(negedge clk);
        check("stray_no_compl", 32'({i_compl_o[0], d_compl_o[0]}), 32'd0);

        // First tie after reset goes to i.
        set_req(PI, 1'b1, 30'h0000010, 32'h0, 1'b0, 4'hF);
        set_req(PD, 1'b1, 30'h0000020, 32'h0, 1'b0, 4'hF);
        transfer(0, PI, 2, 32'h0101_0101, 1'b0);
        transfer(0, PD, 2, 32'h0202_0202, 1'b0);
        set_req(PI, 1'b0, '0, '0, 1'b0, 4'h0);
        set_req(PD, 1'b0, '0, '0, 1'b0, 4'h0);

        // Fixed priority instance: d wins every tie.
        @(negedge clk);
        rst_n = 1'b0;
        clear_exp(0);
        clear_exp(1);
        set_req(PI, 1'b1, 30'h0001000, 32'h0, 1'b0, 4'hF);
        set_req(PD, 1'b1, 30'h0002000, 32'h0, 1'b0, 4'h1);
        @(negedge clk);
        rst_n = 1'b1;
        transfer(1, PD, 2, 32'hF00D0001, 1'b0);
        transfer(1, PD, 3, 32'hF00D0002, 1'b0);
        set_req(PD, 1'b1, 30'h0002004, 32'h99, 1'b1, 4'h8);
        transfer(1, PD, 1, 32'hF00D0003, 1'b0);
        rq_cs[PD] = 1'b0;
        transfer(1, PI, 2, 32'hF00D0004, 1'b0);
        rq_cs[PI] = 1'b0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
